pwm_cfg_sched: RTL
==================

PWM_CFG_SCHED -- requirements
Module: pwm_cfg_sched

Interface
REQ-001 SHALL have parameters: HS_CH_NUM, default 4, number of valid high-speed channels; LS_CH_NUM, default 8, number of valid low-speed channels; ACK_TIMEOUT, default 1024, clock cycles to wait for cfg_ack.
REQ-002 SHALL use one clock and an asynchronous, active-high reset; the ports are sys_clk and sys_rst_n, and sys_rst_n is active-high despite its name.
REQ-003 SHALL have ports, one per line below (name, direction, width, meaning):
 sys_clk  in  1  system clock
 sys_rst_n  in  1  async reset, active-high
 recv_done  in  1  one-cycle pulse; decoded frame fields valid this cycle
 cmd_func  in  8  frame function code (8'h01 HS config, 8'h02 LS config)
 hs_pwm_ch, hs_ctrl_sta, duty_num, pulse_num  in  8 each  HS fields
 pulse_dessert  in  16  HS pulse deassert count
 PAT  in  32  HS period value
 ls_pwm_ch, ls_ctrl_sta  in  8 each  LS fields
 cfg_req  out  1  config write request, held until accepted
 cfg_ch  out  8  target channel
 cfg_addr  out  4  target register
 cfg_data  out  32  write data, zero-extended
 cfg_ack  in  1  write accepted when high together with cfg_req
 busy  out  1  command active or pending
 cmd_done  out  1  one-cycle pulse; command fully applied
 cmd_err  out  1  one-cycle pulse; command aborted or rejected
 err_code  out  2  last error: 0 none, 1 bad func, 2 bad channel, 3 ack timeout
 drop_cnt  out  8  saturating count of dropped commands

Function
REQ-004 SHALL implement the states IDLE, CHECK, WRITE, COMMIT, DONE and ERR.
REQ-005 SHALL, on recv_done in IDLE with no pending entry, capture all fields into the active registers and enter CHECK on the next edge.
REQ-006 SHALL, in CHECK (one cycle): treat cmd_func other than 01/02 as err 1; treat 01 with hs_pwm_ch>=HS_CH_NUM or 02 with ls_pwm_ch>=LS_CH_NUM as err 2; go to ERR on error, otherwise go to WRITE.
REQ-007 SHALL, for func 01, write in order: addr 0 ctrl_sta, 1 duty_num, 2 pulse_dessert, 3 pulse_num, 4 PAT, with cfg_ch=hs_pwm_ch.
REQ-008 SHALL, for func 02, write a single register: addr 8 ls_ctrl_sta, with cfg_ch=ls_pwm_ch.
REQ-009 SHALL, in COMMIT, issue one write with addr 4'hF and data {24'd0, channel} after the last register write.
REQ-010 SHALL keep cfg_req, cfg_ch, cfg_addr and cfg_data stable from assertion until the cycle in which cfg_ack=1; the next write's cfg_req SHALL appear at the earliest in the cycle after that acknowledge (no back-to-back requests).
REQ-011 SHALL ignore cfg_ack when cfg_req=0.
REQ-012 SHALL count cycles per request; if ACK_TIMEOUT cycles elapse without cfg_ack, it SHALL drop cfg_req, skip the remaining writes including COMMIT, and go to ERR with err 3.
REQ-013 SHALL give cfg_ack precedence when it arrives in the same cycle the timeout count expires.
REQ-014 SHALL, in DONE, pulse cmd_done for one cycle and set err_code to 0; in ERR, pulse cmd_err for one cycle and latch err_code.
REQ-015 SHALL, from DONE or ERR, go to CHECK with the pending entry promoted if one is held, otherwise to IDLE.
REQ-016 SHALL hold one pending entry: recv_done in any state other than IDLE, or in IDLE while a pending entry is held, stores the fields into the pending entry if it is empty.
REQ-017 SHALL, on recv_done while the pending entry is full, discard the new command, increment drop_cnt saturating at 255, and leave the active and pending commands untouched.
REQ-018 SHALL drive busy = (state != IDLE) OR pending entry valid.
REQ-019 SHALL give a minimum latency of 2 cycles from recv_done to the first cfg_req, because CHECK takes one cycle.

Reset
REQ-020 SHALL, on sys_rst_n high at any time including mid-write, immediately clear the state to IDLE, cfg_req, cmd_done, cmd_err, busy, cfg_ch, cfg_addr, cfg_data, err_code, drop_cnt and the pending entry, and discard any in-flight command without a completion pulse.

Verification
REQ-021 SHALL cover the following directed scenarios:
- func 01, ch 2, PAT 32'h0001_86A0, cfg_ack tied high -> six writes: addr 0,1,2,3,4,F on cfg_ch 2; cmd_done 1 cycle; err_code 0.
- func 02, ls ch 9 with LS_CH_NUM 8 -> no cfg_req; cmd_err pulse; err_code 2.
- func 01, cfg_ack held low -> cfg_req held exactly ACK_TIMEOUT cycles and then dropped; no COMMIT; err_code 3.
- three recv_done pulses 10 cycles apart with cfg_ack stalled -> first command active, second pending, third dropped; drop_cnt 1; second executes after the first finishes.
- sys_rst_n asserted during the addr 2 write -> outputs zero next edge; no cmd_done; a new command after reset starts again at addr 0.
- func 8'h07 -> cmd_err; err_code 1; no writes.

Source files
------------

// File: rtl/pwm_cfg_sched.sv
// Turns decoded HS/LS PWM frames into a serialized register-write sequence that ends with a channel commit.
// First cfg_req comes 2 cycles after recv_done. Each write waits for cfg_ack or times out. One command is buffered and later ones are dropped.
module pwm_cfg_sched #(
  parameter int HS_CH_NUM   = 4,
  parameter int LS_CH_NUM   = 8,
  parameter int ACK_TIMEOUT = 1024
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        recv_done,
  input  logic [7:0]  cmd_func,
  input  logic [7:0]  hs_pwm_ch,
  input  logic [7:0]  hs_ctrl_sta,
  input  logic [7:0]  duty_num,
  input  logic [7:0]  pulse_num,
  input  logic [15:0] pulse_dessert,
  input  logic [31:0] PAT,
  input  logic [7:0]  ls_pwm_ch,
  input  logic [7:0]  ls_ctrl_sta,
  output logic        cfg_req,
  output logic [7:0]  cfg_ch,
  output logic [3:0]  cfg_addr,
  output logic [31:0] cfg_data,
  input  logic        cfg_ack,
  output logic        busy,
  output logic        cmd_done,
  output logic        cmd_err,
  output logic [1:0]  err_code,
  output logic [7:0]  drop_cnt
);
  typedef struct packed {
    logic [7:0]  func;
    logic [7:0]  hs_ch;
    logic [7:0]  hs_ctrl;
    logic [7:0]  duty;
    logic [7:0]  pnum;
    logic [15:0] pdes;
    logic [31:0] pat;
    logic [7:0]  ls_ch;
    logic [7:0]  ls_ctrl;
  } cmd_t;

  typedef enum logic [2:0] {IDLE, CHECK, WRITE, COMMIT, DONE, ERR} state_t;

  localparam int          TW     = $clog2(ACK_TIMEOUT + 1);
  localparam logic [31:0] HS_LIM = HS_CH_NUM;
  localparam logic [31:0] LS_LIM = LS_CH_NUM;

  state_t        state, state_nxt;
  cmd_t          act, pend, frame;
  logic          pend_vld;
  logic [2:0]    idx;
  logic [TW-1:0] tmo_cnt;
  logic [1:0]    err_nxt;
  logic          is_ls, last_wr, acked, tmo_hit, take_new, promote, issue;
  logic [7:0]    wr_ch;
  logic [3:0]    wr_addr;
  logic [31:0]   wr_data;

  assign frame = '{func: cmd_func, hs_ch: hs_pwm_ch, hs_ctrl: hs_ctrl_sta, duty: duty_num,
                   pnum: pulse_num, pdes: pulse_dessert, pat: PAT, ls_ch: ls_pwm_ch,
                   ls_ctrl: ls_ctrl_sta};

  assign is_ls    = (act.func == 8'h02);
  assign last_wr  = is_ls || (idx == 3'd4);
  assign acked    = cfg_req && cfg_ack;
  // An ack in the expiry cycle wins over the timeout.
  assign tmo_hit  = cfg_req && !cfg_ack && (tmo_cnt == TW'(ACK_TIMEOUT - 1));
  assign take_new = recv_done && (state == IDLE) && !pend_vld;
  assign promote  = ((state == DONE) || (state == ERR)) && pend_vld;
  assign busy     = (state != IDLE) || pend_vld;
  assign cmd_done = (state == DONE);
  assign cmd_err  = (state == ERR);

  always_comb begin
    wr_ch   = is_ls ? act.ls_ch : act.hs_ch;
    wr_addr = 4'hF;
    wr_data = {24'd0, wr_ch};
    if (state != COMMIT) begin
      if (is_ls) begin
        wr_addr = 4'h8;
        wr_data = {24'd0, act.ls_ctrl};
      end else begin
        wr_addr = {1'b0, idx};
        case (idx)
          3'd0:    wr_data = {24'd0, act.hs_ctrl};
          3'd1:    wr_data = {24'd0, act.duty};
          3'd2:    wr_data = {16'd0, act.pdes};
          3'd3:    wr_data = {24'd0, act.pnum};
          default: wr_data = act.pat;
        endcase
      end
    end
  end

  always_comb begin
    state_nxt = state;
    err_nxt   = 2'd0;
    case (state)
      IDLE:  if (take_new) state_nxt = CHECK;
      CHECK: begin
        if (act.func != 8'h01 && act.func != 8'h02)
          err_nxt = 2'd1;
        else if (is_ls ? (32'(act.ls_ch) >= LS_LIM) : (32'(act.hs_ch) >= HS_LIM))
          err_nxt = 2'd2;
        state_nxt = (err_nxt != 2'd0) ? ERR : WRITE;
      end
      WRITE: begin
        if (acked && last_wr) state_nxt = COMMIT;
        else if (tmo_hit) begin
          state_nxt = ERR;
          err_nxt   = 2'd3;
        end
      end
      COMMIT: begin
        if (acked) state_nxt = DONE;
        else if (tmo_hit) begin
          state_nxt = ERR;
          err_nxt   = 2'd3;
        end
      end
      DONE, ERR: state_nxt = pend_vld ? CHECK : IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Requests start on leaving CHECK, and otherwise one idle cycle after each ack.
  assign issue = ((state == CHECK) && (state_nxt == WRITE)) ||
                 (((state == WRITE) || (state == COMMIT)) && !cfg_req);

  always_ff @(posedge sys_clk or posedge sys_rst_n) begin
    if (sys_rst_n) begin
      state    <= IDLE;
      act      <= '0;
      pend     <= '0;
      pend_vld <= 1'b0;
      idx      <= 3'd0;
      tmo_cnt  <= '0;
      cfg_req  <= 1'b0;
      cfg_ch   <= 8'd0;
      cfg_addr <= 4'd0;
      cfg_data <= 32'd0;
      err_code <= 2'd0;
      drop_cnt <= 8'd0;
    end else begin
      state <= state_nxt;

      if (take_new) act <= frame;
      else if (promote) act <= pend;

      if (recv_done && !take_new && !pend_vld) begin
        pend     <= frame;
        pend_vld <= 1'b1;
      end else if (promote) begin
        pend_vld <= 1'b0;
      end
      if (recv_done && !take_new && pend_vld && (drop_cnt != 8'hFF))
        drop_cnt <= drop_cnt + 8'd1;

      if (acked || tmo_hit) begin
        cfg_req <= 1'b0;
      end else if (issue) begin
        cfg_req  <= 1'b1;
        cfg_ch   <= wr_ch;
        cfg_addr <= wr_addr;
        cfg_data <= wr_data;
        tmo_cnt  <= '0;
      end else if (cfg_req) begin
        tmo_cnt <= tmo_cnt + TW'(1);
      end

      if (state_nxt == CHECK) idx <= 3'd0;
      else if (acked && (state == WRITE) && !last_wr) idx <= idx + 3'd1;

      if (state_nxt == DONE) err_code <= 2'd0;
      else if (state_nxt == ERR) err_code <= err_nxt;
    end
  end
endmodule
